// File: rtl/i2s_rx_unit.sv
// i2s_rx_unit: oversampling I2S receiver, 24-bit stereo pairs into a small valid/ready FIFO.
// Optional: define I2S_RX_ERRCHK_EN for the sticky slot-length check on err_out.
module i2s_rx_unit #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_in,
   input  logic        sck_in,
   input  logic        ws_in,
   input  logic        sdo_in,
   input  logic        ready_in,
   output logic        valid_out,
   output logic [23:0] audio0_out,
   output logic [23:0] audio1_out,
   output logic        overflow_out,
   output logic        err_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sr, ws_sr, sdo_sr;
   logic        sck_d, ws_prev, ws_s, sdo_s;
   logic        sck_rise, bnd, word_done;
   logic [4:0]  bit_cnt;
   logic [23:0] shreg, left_hold;
   logic        left_ok, done_q, push_q;
   logic [47:0] push_data;
   logic        cap_left, cap_right;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sck_sr <= '0;
         ws_sr  <= '0;
         sdo_sr <= '0;
         sck_d  <= 1'b0;
      end else begin
         sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck_in};
         ws_sr  <= {ws_sr[SYNC_STAGES-2:0], ws_in};
         sdo_sr <= {sdo_sr[SYNC_STAGES-2:0], sdo_in};
         sck_d  <= sck_sr[SYNC_STAGES-1];
      end

   assign ws_s      = ws_sr[SYNC_STAGES-1];
   assign sdo_s     = sdo_sr[SYNC_STAGES-1];
   assign sck_rise  = sck_sr[SYNC_STAGES-1] & ~sck_d;
   assign bnd       = sck_rise && (ws_s != ws_prev);
   assign word_done = sck_rise && !bnd && (bit_cnt == 5'd23);

   always_ff @(posedge clk or posedge rst)
      if (rst)             state <= IDLE;
      else if (!enable_in) state <= IDLE;
      else                 state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (bnd)
         case (state)
            IDLE:    if (!ws_s) state_nxt = LEFT;
            LEFT:    if (ws_s)  state_nxt = RIGHT;
            RIGHT:   if (!ws_s) state_nxt = LEFT;
            default: state_nxt = IDLE;
         endcase
   end

   always_comb begin
      cap_left  = 1'b0;
      cap_right = 1'b0;
      case (state)
         LEFT:    cap_left  = done_q;
         RIGHT:   cap_right = done_q;
         default: ;
      endcase
   end

   // done_q lags the 24th shift by one clk so the word is stable in shreg when captured
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ws_prev <= 1'b0; bit_cnt <= '0; shreg <= '0; left_hold <= '0;
         left_ok <= 1'b0; done_q <= 1'b0; push_q <= 1'b0; push_data <= '0;
      end else if (!enable_in) begin
         ws_prev <= 1'b0; bit_cnt <= '0; shreg <= '0; left_hold <= '0;
         left_ok <= 1'b0; done_q <= 1'b0; push_q <= 1'b0; push_data <= '0;
      end else begin
         done_q <= word_done;
         push_q <= cap_right && left_ok;
         if (sck_rise) begin
            ws_prev <= ws_s;
            if (bnd) bit_cnt <= '0;
            else begin
               if (bit_cnt < 5'd24)  shreg   <= {shreg[22:0], sdo_s};
               if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
         end
         if (cap_left) begin
            left_hold <= shreg;
            left_ok   <= 1'b1;
         end
         if (cap_right) begin
            push_data <= {left_hold, shreg};
            left_ok   <= 1'b0;
         end
      end

`ifdef I2S_RX_ERRCHK_EN
   logic slot_chk, err_q;
   assign slot_chk = bnd && (state != IDLE);
   always_ff @(posedge clk or posedge rst)
      if (rst)                                err_q <= 1'b0;
      else if (!enable_in)                    err_q <= 1'b0;
      else if (slot_chk && bit_cnt != 5'd31)  err_q <= 1'b1;
   assign err_out = err_q;
`else
   assign err_out = 1'b0;
`endif

   // FIFO: memory plus a registered head (valid_out/audio*_out); total occupancy counts both
   logic [47:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] mcnt, total;
   logic          pop, full, push_ok, ovf, load;

   assign pop     = valid_out && ready_in;
   assign total   = mcnt + CW'(valid_out);
   assign full    = (total == CW'(FIFO_DEPTH));
   assign push_ok = push_q && (!full || pop);
   assign ovf     = push_q && full && !pop;
   assign load    = (mcnt != '0) && (!valid_out || pop);

   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= push_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0; rd_ptr <= '0; mcnt <= '0; overflow_out <= 1'b0;
         valid_out <= 1'b0; audio0_out <= '0; audio1_out <= '0;
      end else if (!enable_in) begin
         wr_ptr <= '0; rd_ptr <= '0; mcnt <= '0; overflow_out <= 1'b0;
         valid_out <= 1'b0; audio0_out <= '0; audio1_out <= '0;
      end else begin
         overflow_out <= ovf;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (load)    rd_ptr <= rd_ptr + 1'b1;
         mcnt <= mcnt + CW'(push_ok) - CW'(load);
         if (load) begin
            valid_out <= 1'b1;
            {audio0_out, audio1_out} <= mem[rd_ptr];
         end else if (pop) begin
            valid_out  <= 1'b0;
            audio0_out <= '0;
            audio1_out <= '0;
         end
      end
endmodule

// File: tb/tb_i2s_rx_unit.sv
// tb_i2s_rx_unit: directed I2S frames at sck = clk/8, scoreboard queue checked by a forked monitor.
module tb_i2s_rx_unit;
   localparam int SS = 2;
`ifdef I2S_RX_ERRCHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, enable_in, sck_in, ws_in, sdo_in, ready_in;
   logic valid_out, overflow_out, err_out;
   logic [23:0] audio0_out, audio1_out;

   int checks = 0, errors = 0;
   int cyc = 0, ovf_cnt = 0, ovf_base = 0;
   int vrise_cyc = -1, t_mark = 0, pulse_cyc = -1;
   logic v_prev = 1'b0;
   logic [47:0] exp_q[$];

   logic [23:0] bp_l [5] = '{24'h100001, 24'h200002, 24'h300003, 24'h400004, 24'h500005};
   logic [23:0] bp_r [5] = '{24'hA0000A, 24'hB0000B, 24'hC0000C, 24'hD0000D, 24'hE0000E};
   logic [23:0] fp_l [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
   logic [23:0] fp_r [5] = '{24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};

   i2s_rx_unit #(.FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .enable_in(enable_in), .sck_in(sck_in), .ws_in(ws_in),
      .sdo_in(sdo_in), .ready_in(ready_in), .valid_out(valid_out), .audio0_out(audio0_out),
      .audio1_out(audio1_out), .overflow_out(overflow_out), .err_out(err_out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (pulse_cyc >= 0) ready_in = (cyc == pulse_cyc - 1);
      end
   endtask

   // one slot: bit k=0 is the boundary edge, data MSB..LSB on k=1..24, zeros after
   task automatic send_slot(input logic ws, input logic [23:0] w, input int nbits,
                            input int en_at, input bit pulse);
      for (int k = 0; k < nbits; k++) begin
         sck_in = 1'b0;
         ws_in  = ws;
         sdo_in = (k >= 1 && k <= 24) ? w[5'(24 - k)] : 1'b0;
         if (k == en_at) enable_in = 1'b1;
         tick(4);
         sck_in = 1'b1;
         if (ws && k == 24) begin
            t_mark = cyc + 1;
            if (pulse) pulse_cyc = cyc + 1 + SS + 2;
         end
         tick(4);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                             input bit expect_it, input bit pulse);
      if (expect_it) exp_q.push_back({l, r});
      send_slot(1'b0, l, 32, -1, 1'b0);
      send_slot(1'b1, r, 32, -1, pulse);
   endtask

   task automatic monitor();
      logic [47:0] e;
      forever begin
         @(negedge clk);
         if (valid_out && !v_prev) vrise_cyc = cyc;
         v_prev = valid_out;
         if (overflow_out) ovf_cnt++;
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pair got=%h exp=none", {audio0_out, audio1_out});
            end else begin
               e = exp_q.pop_front();
               chk("pair", {audio0_out, audio1_out}, e);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable_in = 1'b0; sck_in = 1'b0; ws_in = 1'b0; sdo_in = 1'b0; ready_in = 1'b0;
      fork monitor(); join_none
      tick(3);
      chk("rst_valid", 48'(valid_out), 48'd0);
      chk("rst_audio0", 48'(audio0_out), 48'd0);
      chk("rst_audio1", 48'(audio1_out), 48'd0);
      chk("rst_ovf", 48'(overflow_out), 48'd0);
      chk("rst_err", 48'(err_out), 48'd0);
      rst = 1'b0; enable_in = 1'b1; ready_in = 1'b1;
      tick(2);

      // single frame with latency
      send_slot(1'b1, 24'h0, 32, -1, 1'b0);
      vrise_cyc = -1;
      send_frame(24'hABCDEF, 24'h123456, 1'b1, 1'b0);
      tick(20);
      chk("latency", 48'(vrise_cyc - t_mark), 48'(SS + 3));
      chk("drain_single", 48'(exp_q.size()), 48'd0);

      // enable arrives mid-right: that right word is dropped
      enable_in = 1'b0;
      tick(2);
      send_slot(1'b0, 24'h111111, 32, -1, 1'b0);
      send_slot(1'b1, 24'h00FFFF, 32, 5, 1'b0);
      send_frame(24'h800001, 24'h7FFFFE, 1'b1, 1'b0);
      tick(20);
      chk("drain_midright", 48'(exp_q.size()), 48'd0);

      // backpressure: 5 frames into depth 4
      ready_in = 1'b0;
      ovf_base = ovf_cnt;
      for (int i = 0; i < 5; i++) send_frame(bp_l[i], bp_r[i], i < 4, 1'b0);
      tick(20);
      chk("bp_ovf_pulses", 48'(ovf_cnt - ovf_base), 48'd1);
      chk("bp_head", {23'd0, valid_out, audio0_out}, {23'd0, 1'b1, bp_l[0]});
      ready_in = 1'b1;
      tick(20);
      chk("drain_bp", 48'(exp_q.size()), 48'd0);

      // full FIFO with a pop on the push cycle
      ready_in = 1'b0;
      ovf_base = ovf_cnt;
      for (int i = 0; i < 4; i++) send_frame(fp_l[i], fp_r[i], 1'b1, 1'b0);
      send_frame(fp_l[4], fp_r[4], 1'b1, 1'b1);
      tick(10);
      pulse_cyc = -1;
      ready_in = 1'b0;
      chk("fp_ovf_pulses", 48'(ovf_cnt - ovf_base), 48'd0);
      chk("fp_head", {23'd0, valid_out, audio0_out}, {23'd0, 1'b1, fp_l[1]});
      ready_in = 1'b1;
      tick(20);
      chk("drain_fp", 48'(exp_q.size()), 48'd0);

      // reset mid-frame with two pairs held
      ready_in = 1'b0;
      send_frame(24'h0A0A0A, 24'h0B0B0B, 1'b0, 1'b0);
      send_frame(24'h0C0C0C, 24'h0D0D0D, 1'b0, 1'b0);
      tick(10);
      chk("prerst_valid", 48'(valid_out), 48'd1);
      send_slot(1'b0, 24'h555555, 12, -1, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 48'(valid_out), 48'd0);
      chk("midrst_audio", {audio0_out, audio1_out}, 48'd0);
      tick(2);
      rst = 1'b0;
      ready_in = 1'b1;
      send_slot(1'b0, 24'h555555, 20, -1, 1'b0);
      send_slot(1'b1, 24'hAAAAAA, 32, -1, 1'b0);
      send_frame(24'h13579B, 24'h2468AC, 1'b1, 1'b0);
      tick(20);
      chk("drain_rst", 48'(exp_q.size()), 48'd0);

      // short left slot (30 sck)
      exp_q.push_back({24'hC0FFEE, 24'h0BADF0});
      send_slot(1'b0, 24'hC0FFEE, 30, -1, 1'b0);
      send_slot(1'b1, 24'h0BADF0, 32, -1, 1'b0);
      tick(10);
      chk("err_set", 48'(err_out), 48'(ERR_EXP));
      send_frame(24'h010203, 24'h040506, 1'b1, 1'b0);
      tick(20);
      chk("err_sticky", 48'(err_out), 48'(ERR_EXP));
      chk("drain_err", 48'(exp_q.size()), 48'd0);
      enable_in = 1'b0;
      tick(3);
      chk("err_clr", 48'(err_out), 48'd0);
      chk("dis_valid", 48'(valid_out), 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
